shift_register_piso: RTL and testbench



---
 rtl/shift_register_piso.sv | 115 +++++++++++
 tb/tb_shift_register_piso.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/shift_register_piso.sv
// Parallel-in serial-out shift register: loads a word on Load and emits it MSB-first on Out.
// Define PISO_PARITY_EN to append an even-parity bit after each word.
module shift_register_piso #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic             Out,
    output logic             Busy,
    output logic             Done
);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_d, busy_d, done_d;
    logic               accept;
`ifdef PISO_PARITY_EN
    logic               par_q, par_d;
`endif

    // State and registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            Out     <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            Out     <= out_d;
            Busy    <= busy_d;
            Done    <= done_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next state; a word end can accept a new Load on the same edge for gapless streaming
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        out_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        accept  = 1'b0;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            IDLE: begin
                accept = Load;
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    out_d   = shreg_q[WIDTH-2];
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    busy_d  = 1'b1;
                end else begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
                    out_d   = par_q;
                    busy_d  = 1'b1;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
                    accept  = Load;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_d = IDLE;
                done_d  = 1'b1;
                accept  = Load;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d = SHIFT;
            shreg_d = D;
            out_d   = D[WIDTH-1];
            busy_d  = 1'b1;
            cnt_d   = CNT_W'(WIDTH - 1);
`ifdef PISO_PARITY_EN
            par_d   = ^D;
`endif
        end
    end

endmodule

// File: tb/tb_shift_register_piso.sv
// Scoreboard bench for shift_register_piso: stimulus queues expected serial bits, a monitor checks Out/Busy/Done.
module tb_shift_register_piso;

    localparam int unsigned WIDTH = 4;
`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int unsigned WORD_CYC = WIDTH + 1;
`else
    localparam bit PAR = 1'b0;
    localparam int unsigned WORD_CYC = WIDTH;
`endif

    typedef struct packed {
        logic b;
        logic last;
    } item_t;

    logic             Clk = 1'b0;
    logic             Rst_n;
    logic             Load;
    logic [WIDTH-1:0] D;
    logic             Out, Busy, Done;

    item_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    exp_words = 0;
    int    obs_done = 0;
    logic  exp_done_next = 1'b0;

    shift_register_piso #(.WIDTH(WIDTH)) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .Load (Load),
        .D    (D),
        .Out  (Out),
        .Busy (Busy),
        .Done (Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Hand-computed serial pattern: bits MSB first, then the supplied even-parity bit when enabled
    task automatic push_word(input logic [WIDTH-1:0] d, input logic p);
        for (int i = WIDTH - 1; i >= 0; i--)
            exp_q.push_back('{b: d[i], last: (i == 0) && !PAR});
        if (PAR)
            exp_q.push_back('{b: p, last: 1'b1});
    endtask

    // Drive Load for one edge; expected bits are queued only for words the DUT must send
    task automatic issue(input logic [WIDTH-1:0] d, input logic p, input bit sent, input bit completes);
        Load = 1'b1;
        D    = d;
        if (sent) push_word(d, p);
        if (completes) exp_words++;
        @(posedge Clk);
        #1;
        Load = 1'b0;
        D    = WIDTH'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Monitor: pops one expected bit for every cycle Busy is high
    always @(negedge Clk) begin
        item_t it;
        if (!Rst_n) begin
            chk("rst_out", Out, 1'b0);
            chk("rst_busy", Busy, 1'b0);
            chk("rst_done", Done, 1'b0);
            exp_done_next = 1'b0;
        end else begin
            chk("done", Done, exp_done_next);
            exp_done_next = 1'b0;
            if (Done === 1'b1) obs_done++;
            if (Busy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("extra_busy", Busy, 1'b0);
                end else begin
                    it = exp_q.pop_front();
                    chk("out", Out, it.b);
                    exp_done_next = it.last;
                end
            end else begin
                chk("idle_out", Out, 1'b0);
            end
        end
    end

    initial begin
        Rst_n = 1'b0;
        Load  = 1'b1;
        D     = 4'hF;
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        Load  = 1'b0;
        D     = '0;
        idle(2);

        // Single word
        issue(4'b1011, 1'b1, 1'b1, 1'b1);
        idle(WORD_CYC + 2);

        // Back-to-back: second load lands on the word-end edge
        issue(4'b1100, 1'b0, 1'b1, 1'b1);
        idle(WORD_CYC - 1);
        issue(4'b0011, 1'b0, 1'b1, 1'b1);
        idle(WORD_CYC + 2);

        // Load during an in-flight word is ignored
        issue(4'b1000, 1'b1, 1'b1, 1'b1);
        idle(1);
        issue(4'b1111, 1'b0, 1'b0, 1'b0);
        idle(WORD_CYC + 2);

        // Asynchronous reset mid-word aborts it without Done
        issue(4'b1111, 1'b0, 1'b1, 1'b0);
        @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_out", Out, 1'b0);
        chk("async_rst_busy", Busy, 1'b0);
        chk("async_rst_done", Done, 1'b0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        idle(2);

        issue(4'b0101, 1'b0, 1'b1, 1'b1);
        idle(WORD_CYC + 1);
        issue(4'b1001, 1'b0, 1'b1, 1'b1);
        idle(WORD_CYC - 1);
        issue(4'b0111, 1'b1, 1'b1, 1'b1);
        idle(WORD_CYC + 3);

        chk_int("queue_drained", exp_q.size(), 0);
        chk_int("done_count", obs_done, exp_words);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
